// File: rtl/async_fifo_cfg.sv
// Dual-clock FIFO with Gray-coded pointer crossing, configurable synchronizer depth,
// FWFT or registered read, per-side fill levels and sticky overflow/underflow flags.
module async_fifo_cfg #(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int FWFT             = 1,
  parameter int ALMOST_FULL_GAP  = 3,
  parameter int ALMOST_EMPTY_GAP = 3
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_GAP  = PW'(ALMOST_FULL_GAP);
  localparam logic [PW-1:0] AE_GAP  = PW'(ALMOST_EMPTY_GAP);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_gray_q, wr_gray_d;
  logic [PW-1:0] rd_gray_sync_q [SYNC_STAGES];
  logic [PW-1:0] rd_sync_bin, wr_lvl;
  logic          overflow_q, overflow_d, wr_accept;

  always_comb begin
    rd_sync_bin = gray2bin(rd_gray_sync_q[SYNC_STAGES-1]);
    wr_lvl      = wr_ptr_q - rd_sync_bin;
    wr_accept   = wr_en && (wr_lvl != DEPTH_P);
    wr_ptr_d    = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_accept};
    // Gray is taken from the next pointer so the crossing value never lags wr_ptr_q.
    wr_gray_d   = wr_ptr_d ^ (wr_ptr_d >> 1);
    overflow_d  = overflow_q | (wr_en && (wr_lvl == DEPTH_P));
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_ptr_q   <= '0;
      wr_gray_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) rd_gray_sync_q[i] <= '0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      wr_gray_q         <= wr_gray_d;
      overflow_q        <= overflow_d;
      rd_gray_sync_q[0] <= rd_gray_q;
      for (int i = 1; i < SYNC_STAGES; i++) rd_gray_sync_q[i] <= rd_gray_sync_q[i-1];
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_accept) ram_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

  assign wr_level    = wr_lvl;
  assign full        = (wr_lvl == DEPTH_P);
  assign almost_full = ((DEPTH_P - wr_lvl) < AF_GAP);
  assign overflow    = overflow_q;

  // ---------------- read domain ----------------
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, rd_gray_q, rd_gray_d;
  logic [PW-1:0] wr_gray_sync_q [SYNC_STAGES];
  logic [PW-1:0] wr_sync_bin, rd_lvl;
  logic          underflow_q, underflow_d, rd_accept;

  always_comb begin
    wr_sync_bin = gray2bin(wr_gray_sync_q[SYNC_STAGES-1]);
    rd_lvl      = wr_sync_bin - rd_ptr_q;
    rd_accept   = rd_en && (rd_lvl != '0);
    rd_ptr_d    = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_accept};
    rd_gray_d   = rd_ptr_d ^ (rd_ptr_d >> 1);
    underflow_d = underflow_q | (rd_en && (rd_lvl == '0));
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_q    <= '0;
      rd_gray_q   <= '0;
      underflow_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) wr_gray_sync_q[i] <= '0;
    end else begin
      rd_ptr_q          <= rd_ptr_d;
      rd_gray_q         <= rd_gray_d;
      underflow_q       <= underflow_d;
      wr_gray_sync_q[0] <= wr_gray_q;
      for (int i = 1; i < SYNC_STAGES; i++) wr_gray_sync_q[i] <= wr_gray_sync_q[i-1];
    end
  end

  assign rd_level     = rd_lvl;
  assign empty        = (rd_lvl == '0);
  assign almost_empty = (rd_lvl < AE_GAP);
  assign underflow    = underflow_q;

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = ram_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      assign rd_valid = (rd_lvl != '0);
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;
      always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_accept;
          if (rd_accept) rd_data_q <= ram_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
      end
      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate
endmodule

// File: tb/tb_async_fifo_cfg.sv
// Directed bench for async_fifo_cfg: three instances (default FWFT, registered read,
// DEPTH=8 with three sync stages) sharing clocks and resets.
module tb_async_fifo_cfg;
  logic wr_clk = 1'b0, rd_clk = 1'b0;
  logic wr_rst_n = 1'b0, rd_rst_n = 1'b0;
  int   wr_half = 50, rd_half = 65;
  int   n_cmp = 0, n_err = 0;
  int   rd_edges = 0;
  logic [15:0] exp_q[$];

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;
  always @(posedge rd_clk) rd_edges++;

  // Instance A: defaults (FWFT)
  logic a_wr_en = 0, a_rd_en = 0;
  logic [15:0] a_wr_data = '0, a_rd_data;
  logic a_full, a_afull, a_ovf, a_rd_valid, a_empty, a_aempty, a_udf;
  logic [4:0] a_wr_level, a_rd_level;
  async_fifo_cfg u_a (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .wr_en(a_wr_en), .wr_data(a_wr_data), .full(a_full), .almost_full(a_afull),
    .wr_level(a_wr_level), .overflow(a_ovf), .rd_en(a_rd_en), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .empty(a_empty), .almost_empty(a_aempty),
    .rd_level(a_rd_level), .underflow(a_udf));

  // Instance B: registered read
  logic b_wr_en = 0, b_rd_en = 0;
  logic [15:0] b_wr_data = '0, b_rd_data;
  logic b_full, b_afull, b_ovf, b_rd_valid, b_empty, b_aempty, b_udf;
  logic [4:0] b_wr_level, b_rd_level;
  async_fifo_cfg #(.FWFT(0)) u_b (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .wr_en(b_wr_en), .wr_data(b_wr_data), .full(b_full), .almost_full(b_afull),
    .wr_level(b_wr_level), .overflow(b_ovf), .rd_en(b_rd_en), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .empty(b_empty), .almost_empty(b_aempty),
    .rd_level(b_rd_level), .underflow(b_udf));

  // Instance C: DEPTH=8, three sync stages
  logic c_wr_en = 0, c_rd_en = 0;
  logic [15:0] c_wr_data = '0, c_rd_data;
  logic c_full, c_afull, c_ovf, c_rd_valid, c_empty, c_aempty, c_udf;
  logic [3:0] c_wr_level, c_rd_level;
  async_fifo_cfg #(.ADDR_WIDTH(3), .SYNC_STAGES(3)) u_c (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
    .wr_en(c_wr_en), .wr_data(c_wr_data), .full(c_full), .almost_full(c_afull),
    .wr_level(c_wr_level), .overflow(c_ovf), .rd_en(c_rd_en), .rd_data(c_rd_data),
    .rd_valid(c_rd_valid), .empty(c_empty), .almost_empty(c_aempty),
    .rd_level(c_rd_level), .underflow(c_udf));

  task automatic do_reset;
    a_wr_en = 0; a_rd_en = 0; b_wr_en = 0; b_rd_en = 0; c_wr_en = 0; c_rd_en = 0;
    wr_rst_n = 0; rd_rst_n = 0;
    repeat (3) @(negedge wr_clk);
    repeat (3) @(negedge rd_clk);
    @(negedge wr_clk) wr_rst_n = 1;
    @(negedge rd_clk) rd_rst_n = 1;
    repeat (2) @(negedge wr_clk);
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge rd_clk);
    n_cmp++; if (a_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %0h exp 0", a_full); end
    n_cmp++; if (a_afull !== 1'b0) begin n_err++; $display("FAIL rst_afull: got %0h exp 0", a_afull); end
    n_cmp++; if (a_wr_level !== 5'd0) begin n_err++; $display("FAIL rst_wr_level: got %0d exp 0", a_wr_level); end
    n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %0h exp 0", a_ovf); end
    n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %0h exp 1", a_empty); end
    n_cmp++; if (a_aempty !== 1'b1) begin n_err++; $display("FAIL rst_aempty: got %0h exp 1", a_aempty); end
    n_cmp++; if (a_rd_level !== 5'd0) begin n_err++; $display("FAIL rst_rd_level: got %0d exp 0", a_rd_level); end
    n_cmp++; if (a_udf !== 1'b0) begin n_err++; $display("FAIL rst_udf: got %0h exp 0", a_udf); end
    n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid: got %0h exp 0", a_rd_valid); end
    n_cmp++; if (b_rd_data !== 16'h0000) begin n_err++; $display("FAIL rst_b_rd_data: got %0h exp 0", b_rd_data); end
    n_cmp++; if (b_rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_b_rd_valid: got %0h exp 0", b_rd_valid); end
    n_cmp++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL rst_c_empty: got %0h exp 1", c_empty); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      @(negedge wr_clk);
      n_cmp++; if (a_wr_level !== 5'(i)) begin n_err++; $display("FAIL fill_level[%0d]: got %0d exp %0d", i, a_wr_level, i); end
      n_cmp++; if (a_full !== 1'b0) begin n_err++; $display("FAIL fill_full[%0d]: got %0h exp 0", i, a_full); end
      n_cmp++; if (a_afull !== (i >= 14)) begin n_err++; $display("FAIL fill_afull[%0d]: got %0h exp %0h", i, a_afull, (i >= 14)); end
      a_wr_en = 1; a_wr_data = 16'(i);
    end
    @(negedge wr_clk);
    n_cmp++; if (a_wr_level !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d exp 16", a_wr_level); end
    n_cmp++; if (a_full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %0h exp 1", a_full); end
    n_cmp++; if (a_afull !== 1'b1) begin n_err++; $display("FAIL full_afull: got %0h exp 1", a_afull); end
    n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL full_ovf_early: got %0h exp 0", a_ovf); end
    a_wr_data = 16'hDEAD;
    @(negedge wr_clk) a_wr_en = 0;
    n_cmp++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL overflow: got %0h exp 1", a_ovf); end
    n_cmp++; if (a_wr_level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d exp 16", a_wr_level); end
  endtask

  task automatic test_drain;
    for (int k = 0; k < 10 && a_rd_level != 5'd16; k++) @(negedge rd_clk);
    n_cmp++; if (a_rd_level !== 5'd16) begin n_err++; $display("FAIL drain_sync_level: got %0d exp 16", a_rd_level); end
    for (int i = 0; i < 16; i++) begin
      @(negedge rd_clk);
      n_cmp++; if (a_rd_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %0h exp 1", i, a_rd_valid); end
      n_cmp++; if (a_rd_data !== 16'(i)) begin n_err++; $display("FAIL drain_data[%0d]: got %0h exp %0h", i, a_rd_data, i); end
      n_cmp++; if (a_rd_level !== 5'(16 - i)) begin n_err++; $display("FAIL drain_level[%0d]: got %0d exp %0d", i, a_rd_level, 16 - i); end
      n_cmp++; if (a_aempty !== ((16 - i) < 3)) begin n_err++; $display("FAIL drain_aempty[%0d]: got %0h exp %0h", i, a_aempty, ((16 - i) < 3)); end
      a_rd_en = 1;
    end
    @(negedge rd_clk);
    n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %0h exp 1", a_empty); end
    n_cmp++; if (a_rd_level !== 5'd0) begin n_err++; $display("FAIL drain_level_end: got %0d exp 0", a_rd_level); end
    n_cmp++; if (a_udf !== 1'b0) begin n_err++; $display("FAIL drain_udf_early: got %0h exp 0", a_udf); end
    @(negedge rd_clk) a_rd_en = 0;
    n_cmp++; if (a_udf !== 1'b1) begin n_err++; $display("FAIL underflow: got %0h exp 1", a_udf); end
    for (int k = 0; k < 10 && a_full; k++) @(negedge wr_clk);
    n_cmp++; if (a_full !== 1'b0) begin n_err++; $display("FAIL full_release: got %0h exp 0", a_full); end
    n_cmp++; if (a_wr_level !== 5'd0) begin n_err++; $display("FAIL wr_level_release: got %0d exp 0", a_wr_level); end
  endtask

  task automatic test_registered;
    int start, n;
    @(negedge wr_clk) b_wr_en = 1; b_wr_data = 16'hA5A5;
    @(posedge wr_clk) start = rd_edges;
    @(negedge wr_clk) b_wr_en = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge rd_clk);
      if (!b_empty) break;
    end
    n = rd_edges - start;
    n_cmp++; if (b_empty !== 1'b0 || n > 3) begin n_err++; $display("FAIL reg_empty_latency: got %0d edges (empty=%0h) exp <=3", n, b_empty); end
    n_cmp++; if (b_rd_valid !== 1'b0) begin n_err++; $display("FAIL reg_valid_pre: got %0h exp 0", b_rd_valid); end
    b_rd_en = 1;
    @(negedge rd_clk) b_rd_en = 0;
    n_cmp++; if (b_rd_valid !== 1'b1) begin n_err++; $display("FAIL reg_valid: got %0h exp 1", b_rd_valid); end
    n_cmp++; if (b_rd_data !== 16'hA5A5) begin n_err++; $display("FAIL reg_data: got %0h exp a5a5", b_rd_data); end
    for (int k = 0; k < 2; k++) begin
      @(negedge rd_clk);
      n_cmp++; if (b_rd_valid !== 1'b0) begin n_err++; $display("FAIL reg_valid_after[%0d]: got %0h exp 0", k, b_rd_valid); end
      n_cmp++; if (b_rd_data !== 16'hA5A5) begin n_err++; $display("FAIL reg_data_hold[%0d]: got %0h exp a5a5", k, b_rd_data); end
    end
  endtask

  task automatic test_small;
    int start, n;
    @(negedge wr_clk) c_wr_en = 1; c_wr_data = 16'h0C00;
    @(posedge wr_clk) start = rd_edges;
    @(negedge wr_clk) c_wr_en = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge rd_clk);
      if (!c_empty) break;
    end
    n = rd_edges - start;
    n_cmp++; if (c_empty !== 1'b0 || n > 4) begin n_err++; $display("FAIL small_empty_latency: got %0d edges (empty=%0h) exp <=4", n, c_empty); end
    for (int i = 1; i < 8; i++) begin
      @(negedge wr_clk);
      n_cmp++; if (c_full !== 1'b0 || c_wr_level !== 4'(i)) begin n_err++; $display("FAIL small_fill[%0d]: got full=%0h level=%0d exp full=0 level=%0d", i, c_full, c_wr_level, i); end
      c_wr_en = 1; c_wr_data = 16'(16'h0C00 + i);
    end
    @(negedge wr_clk) c_wr_en = 0;
    n_cmp++; if (c_full !== 1'b1) begin n_err++; $display("FAIL small_full: got %0h exp 1", c_full); end
    n_cmp++; if (c_wr_level !== 4'd8) begin n_err++; $display("FAIL small_level: got %0d exp 8", c_wr_level); end
  endtask

  task automatic test_stream(input int wh, input int rh);
    int sent, got;
    wr_half = wh; rd_half = rh;
    do_reset();
    exp_q.delete();
    sent = 0; got = 0;
    fork
      begin
        for (int cyc = 0; sent < 100 && cyc < 4000; cyc++) begin
          @(negedge wr_clk);
          n_cmp++; if (a_wr_level > 5'd16) begin n_err++; $display("FAIL stream_wr_level: got %0d exp <=16", a_wr_level); end
          if (!a_full && $urandom_range(0, 99) < 60) begin
            a_wr_en = 1; a_wr_data = 16'hC000 | 16'(sent);
            exp_q.push_back(a_wr_data); sent++;
          end else a_wr_en = 0;
        end
        @(negedge wr_clk) a_wr_en = 0;
      end
      begin
        for (int cyc = 0; got < 100 && cyc < 6000; cyc++) begin
          @(negedge rd_clk);
          n_cmp++; if (a_rd_level > 5'd16) begin n_err++; $display("FAIL stream_rd_level: got %0d exp <=16", a_rd_level); end
          if (!a_empty && $urandom_range(0, 99) < 60) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL stream_extra: got %0h exp nothing", a_rd_data); end
            else if (a_rd_valid !== 1'b1 || a_rd_data !== exp_q[0]) begin
              n_err++; $display("FAIL stream_data[%0d]: got %0h valid=%0h exp %0h", got, a_rd_data, a_rd_valid, exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            a_rd_en = 1; got++;
          end else a_rd_en = 0;
        end
        @(negedge rd_clk) a_rd_en = 0;
      end
    join
    n_cmp++; if (got != 100 || sent != 100) begin n_err++; $display("FAIL stream_timeout: got sent=%0d recv=%0d exp 100/100", sent, got); end
    n_cmp++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL stream_ovf: got %0h exp 0", a_ovf); end
    n_cmp++; if (a_udf !== 1'b0) begin n_err++; $display("FAIL stream_udf: got %0h exp 0", a_udf); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk) a_wr_en = 1; a_wr_data = 16'(16'h0050 + i);
    end
    @(negedge wr_clk) a_wr_en = 0;
    for (int k = 0; k < 10 && a_rd_level != 5'd5; k++) @(negedge rd_clk);
    n_cmp++; if (a_rd_level !== 5'd5) begin n_err++; $display("FAIL mid_pre_level: got %0d exp 5", a_rd_level); end
    #7 wr_rst_n = 0; rd_rst_n = 0;
    #1;
    n_cmp++; if (a_full !== 1'b0 || a_afull !== 1'b0 || a_wr_level !== 5'd0 || a_ovf !== 1'b0) begin
      n_err++; $display("FAIL mid_wr_side: got full=%0h afull=%0h level=%0d ovf=%0h exp 0/0/0/0", a_full, a_afull, a_wr_level, a_ovf);
    end
    n_cmp++; if (a_empty !== 1'b1 || a_aempty !== 1'b1 || a_rd_level !== 5'd0 || a_udf !== 1'b0 || a_rd_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_rd_side: got empty=%0h aempty=%0h level=%0d udf=%0h valid=%0h exp 1/1/0/0/0", a_empty, a_aempty, a_rd_level, a_udf, a_rd_valid);
    end
    n_cmp++; if (b_rd_data !== 16'h0000 || b_rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_b_rd: got data=%0h valid=%0h exp 0/0", b_rd_data, b_rd_valid); end
    repeat (3) @(negedge wr_clk);
    @(negedge wr_clk) wr_rst_n = 1;
    @(negedge rd_clk) rd_rst_n = 1;
    @(negedge wr_clk) a_wr_en = 1; a_wr_data = 16'h1234;
    @(negedge wr_clk) a_wr_en = 0;
    for (int k = 0; k < 10 && a_empty; k++) @(negedge rd_clk);
    n_cmp++; if (a_rd_valid !== 1'b1 || a_rd_data !== 16'h1234) begin n_err++; $display("FAIL mid_first_word: got %0h valid=%0h exp 1234", a_rd_data, a_rd_valid); end
    n_cmp++; if (a_rd_level !== 5'd1) begin n_err++; $display("FAIL mid_level: got %0d exp 1", a_rd_level); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_registered();
    test_small();
    test_stream(50, 65);
    test_stream(65, 50);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/async_fifo_cfg.md
Name: async_fifo_cfg

Overview:
Second-generation dual-clock FIFO. Crosses DATA_WIDTH words from the wr_clk domain to the rd_clk domain using Gray-coded pointers.
- Synchronizer depth is configurable.
- Read mode is selectable: first-word-fall-through (FWFT) or registered.
- Each side reports its own fill level.
- Sticky overflow/underflow error flags.
Used wherever a stream crosses between unrelated clock domains.

Parameters:
DATA_WIDTH, 16, word width in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH; legal values >= 2
SYNC_STAGES, 2, flop stages per pointer synchronizer; legal values >= 2
FWFT, 1, 1 = first-word-fall-through read; 0 = registered read with one-cycle latency
ALMOST_FULL_GAP, 3, almost_full asserts when free entries < this value; legal range 1..DEPTH-1
ALMOST_EMPTY_GAP, 3, almost_empty asserts when stored entries < this value; legal range 1..DEPTH-1

Ports:
wr_clk  in  1  write clock
wr_rst_n  in  1  write-domain reset, asynchronous, active-low
rd_clk  in  1  read clock
rd_rst_n  in  1  read-domain reset, asynchronous, active-low
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
full  out  1  no free entries (wr_clk domain)
almost_full  out  1  free entries < ALMOST_FULL_GAP
wr_level  out  ADDR_WIDTH+1  stored entries as seen by the write side, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
rd_en  in  1  read/pop request
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data is valid this cycle
empty  out  1  no stored entries (rd_clk domain)
almost_empty  out  1  stored entries < ALMOST_EMPTY_GAP
rd_level  out  ADDR_WIDTH+1  stored entries as seen by the read side, 0..DEPTH
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Pointers: binary wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits, wrapping modulo 2**(ADDR_WIDTH+1).
  - The MSB distinguishes full from empty.
  - Gray code = ptr ^ (ptr >> 1), registered in the source domain before crossing.
- Synchronizers:
  - Gray rd_ptr passes through SYNC_STAGES wr_clk flops; Gray wr_ptr passes through SYNC_STAGES rd_clk flops.
  - Synchronized values are Gray-to-binary converted across all ADDR_WIDTH+1 bits, MSB included.
- Write side:
  - An accepted write (wr_en && !full) stores wr_data at ram[wr_ptr[ADDR_WIDTH-1:0]] and increments wr_ptr.
  - wr_en && full: the write is dropped, wr_ptr holds, and overflow is set.
- Write-side flags:
  - wr_level = wr_ptr - sync_rd_bin, computed modulo 2**(ADDR_WIDTH+1).
  - full = (wr_level == DEPTH).
  - almost_full = (DEPTH - wr_level < ALMOST_FULL_GAP).
  - All are combinational from registers.
- Read side:
  - rd_level = sync_wr_bin - rd_ptr.
  - empty = (rd_level == 0).
  - almost_empty = (rd_level < ALMOST_EMPTY_GAP).
  - Accepted read = rd_en && !empty; it increments rd_ptr.
  - rd_en && empty: ignored, and underflow is set.
- FWFT=1:
  - rd_data = ram[rd_ptr[ADDR_WIDTH-1:0]], combinational.
  - rd_valid = !empty.
  - rd_data is don't-care while rd_valid = 0.
- FWFT=0:
  - On an accepted read, rd_data is registered with the head word at that rd_clk edge.
  - rd_valid pulses high for exactly one cycle after each accepted read.
  - rd_data holds its value otherwise.
- Flags are conservative, never optimistic:
  - empty deasserts within SYNC_STAGES+1 rd_clk edges after the writing wr_clk edge.
  - full deasserts within SYNC_STAGES+1 wr_clk edges after the reading rd_clk edge.
  - A write into a not-full FIFO is never lost; a read from a non-empty FIFO never returns stale or duplicated data.
- Simultaneous read and write while non-empty and non-full: both are accepted, and levels net to no change once synchronized.
- Wrap-around: the data sequence must be unbroken across the pointer MSB toggle.
- Reset values:
  - wr_rst_n low: wr_ptr, Gray wr_ptr, rd-pointer sync chain and overflow are cleared. full=0, almost_full=0, wr_level=0.
  - rd_rst_n low: rd_ptr, Gray rd_ptr, wr-pointer sync chain and underflow are cleared. empty=1, almost_empty=1, rd_level=0, rd_valid=0, rd_data=0 (FWFT=0).
- RAM is not reset.
- Reset mid-operation: a flush requires both resets asserted with overlapping low periods. Asserting only one reset is unsupported.
- Deassertion of each reset is synchronized externally to its own clock.
- overflow and underflow clear only on their own domain's reset.

Test Plan:
- Defaults, wr_clk 10 ns, rd_clk 13 ns, write 0x0000..0x000F with no reads:
  - full asserts after the 16th write; almost_full asserts at wr_level=14; wr_level=16.
  - A 17th write with data 0xDEAD sets overflow and is not stored.
- From full, read 16 words with FWFT=1 at rd_en=1 continuous:
  - rd_data sequence is 0x0000..0x000F.
  - empty=1 after the 16th read; almost_empty asserts at rd_level=2.
  - An extra rd_en sets underflow.
- FWFT=0, write 0xA5A5 into an empty FIFO:
  - empty deasserts within 3 rd_clk edges.
  - rd_en for one cycle gives rd_valid high for exactly one cycle, the next cycle, with rd_data=0xA5A5.
  - rd_data holds 0xA5A5 afterwards.
- Streaming with random wr_en/rd_en across 100 words (6+ pointer wraps), clock ratios 10/13 ns and 13/10 ns:
  - Output equals input order exactly; no overflow or underflow.
  - wr_level and rd_level are never > 16.
- SYNC_STAGES=3, ADDR_WIDTH=3 (DEPTH=8), write one word:
  - empty deasserts within 4 rd_clk edges.
  - Filling gives full at exactly 8 entries.
- With 5 entries stored, assert wr_rst_n and rd_rst_n together mid-stream:
  - All outputs return to the reset values above.
  - After release, the next written word 0x1234 is the first word read.
